// File: rtl/clkgen_if.sv
// Front-panel request / phase-pulse bundle between the panel logic and the clock sequencer.
interface clkgen_if #(
   parameter int unsigned PHASES = 4,
   parameter int unsigned DIV_W  = 8
);
   logic              run_req;
   logic              halt_req;
   logic              step_req;
   logic [DIV_W-1:0]  div_sel;
   logic [PHASES-1:0] phase_en;
   logic              cycle_done;
   logic              running;
   logic              halted;

   modport master (
      output run_req, halt_req, step_req, div_sel,
      input  phase_en, cycle_done, running, halted
   );

   modport slave (
      input  run_req, halt_req, step_req, div_sel,
      output phase_en, cycle_done, running, halted
   );
endinterface

// File: rtl/clkgen_ctrl.sv
// Run/halt/single-step sequencer: divides clk by D+1 and emits one-hot phase pulses.
module clkgen_ctrl #(
   parameter int unsigned PHASES = 4,
   parameter int unsigned DIV_W  = 8
) (
   input  logic      clk,
   input  logic      nrst,
   clkgen_if.slave   bus
);
   localparam int unsigned IDX_W = (PHASES > 1) ? $clog2(PHASES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PHASES - 1);

   typedef enum logic [1:0] {HALTED, RUN, STEP, DRAIN} state_e;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              run_q, halt_q, step_q;
   logic [PHASES-1:0] phase_en_q, phase_en_d;
   logic              cycle_done_q, cycle_done_d;
   logic              running_q, running_d;
   logic              halted_q, halted_d;

   logic run_e, halt_e, step_e, tick, last;

   // Next-state, divider and phase-pulse generation.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      div_d        = div_q;
      phase_en_d   = '0;
      cycle_done_d = 1'b0;

      run_e  = bus.run_req  & ~run_q;
      halt_e = bus.halt_req & ~halt_q;
      step_e = bus.step_req & ~step_q;
      tick   = (cnt_q == div_q);
      last   = tick && (idx_q == LAST_IDX);

      case (state_q)
         HALTED: begin
            idx_d = '0;
            cnt_d = '0;
            // halt edge is a no-op here; step wins over run
            if (step_e) begin
               state_d = STEP;
               div_d   = bus.div_sel;
            end else if (run_e) begin
               state_d = RUN;
               div_d   = bus.div_sel;
            end
         end
         RUN, STEP, DRAIN: begin
            if (tick) begin
               cnt_d      = '0;
               phase_en_d = PHASES'(1) << idx_q;
               idx_d      = last ? '0 : idx_q + IDX_W'(1);
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
            // ratio changes only land on an instruction-cycle boundary
            if (last) begin
               div_d        = bus.div_sel;
               cycle_done_d = 1'b1;
            end
            if (state_q == RUN) begin
               if (halt_e) state_d = last ? HALTED : DRAIN;
            end else if (last) begin
               state_d = HALTED;
            end
         end
         default: state_d = HALTED;
      endcase

      running_d = (state_d != HALTED);
      halted_d  = (state_d == HALTED);
   end

   // State, divider and registered outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= HALTED;
         idx_q        <= '0;
         cnt_q        <= '0;
         div_q        <= '0;
         run_q        <= 1'b0;
         halt_q       <= 1'b0;
         step_q       <= 1'b0;
         phase_en_q   <= '0;
         cycle_done_q <= 1'b0;
         running_q    <= 1'b0;
         halted_q     <= 1'b1;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         div_q        <= div_d;
         run_q        <= bus.run_req;
         halt_q       <= bus.halt_req;
         step_q       <= bus.step_req;
         phase_en_q   <= phase_en_d;
         cycle_done_q <= cycle_done_d;
         running_q    <= running_d;
         halted_q     <= halted_d;
      end
   end

   assign bus.phase_en   = phase_en_q;
   assign bus.cycle_done = cycle_done_q;
   assign bus.running    = running_q;
   assign bus.halted     = halted_q;
endmodule
